keypad_entry_controller: RTL

//  Sequences the keypad path: takes decoded key codes + data-valid from the keypad

---
 rtl/keypad_pkg.sv | 17 +
 rtl/entry_timer.sv | 36 +++
 rtl/keypad_entry_controller.sv | 127 ++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared key codes, FSM state type and digit helper for the keypad entry path
package keypad_pkg;

  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_COMMIT
  } state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/entry_timer.sv
// rtl/entry_timer.sv - inactivity counter, pulses expire after TIMEOUT_CYCLES enabled idle cycles
module entry_timer #(
  parameter int TIMEOUT_CYCLES = 250_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

      logic [CW-1:0] cnt;

      // A clear in the expiry cycle wins, so a key landing on that edge is never lost.
      assign expire = enable && !clear && (cnt == LAST);

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          cnt <= '0;
        end else if (clear || expire) begin
          cnt <= '0;
        end else if (enable) begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/keypad_entry_controller.sv
// rtl/keypad_entry_controller.sv - assembles BCD key entries and commits them at an auto-incrementing address
module keypad_entry_controller
  import keypad_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 250_000_000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [3:0]                    key_data,
  input  logic                          key_dav,
  input  logic                          addr_load,
  input  logic [ADDR_W-1:0]             addr_in,
  output logic [4*N_DIGITS-1:0]         entry_value,
  output logic [$clog2(N_DIGITS+1)-1:0] digit_count,
  output logic                          wr_en,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [4*N_DIGITS-1:0]         wr_data,
  output logic                          overflow,
  output logic                          timeout
);

  localparam int DW = 4 * N_DIGITS;
  localparam int CW = $clog2(N_DIGITS + 1);
  localparam logic [CW-1:0] FULL = CW'(N_DIGITS);

  state_t          state;
  logic            dav_q;
  logic            accept;
  logic            key_digit;
  logic            key_star;
  logic            key_hash;
  logic            timer_clear;
  logic            expire;
  logic [DW-1:0]   shifted;

  assign accept    = key_dav && !dav_q;
  assign key_digit = accept && is_digit(key_data);
  assign key_star  = accept && (key_data == KEY_STAR);
  assign key_hash  = accept && (key_data == KEY_HASH);
  assign shifted   = DW'({entry_value, key_data});

  // Codes C-F are not part of the clear set, so junk keys cannot hold an entry open.
  assign timer_clear = (state != ST_ENTRY) || key_digit || key_star || key_hash;

  entry_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .clear (timer_clear),
    .enable(state == ST_ENTRY),
    .expire(expire)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      dav_q       <= 1'b1;
      entry_value <= '0;
      digit_count <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      overflow    <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      dav_q    <= key_dav;
      wr_en    <= 1'b0;
      overflow <= 1'b0;
      timeout  <= 1'b0;
      if (addr_load) begin
        wr_addr <= addr_in;
      end

      case (state)
        ST_IDLE: begin
          if (key_digit) begin
            entry_value <= shifted;
            digit_count <= CW'(1);
            state       <= ST_ENTRY;
          end
        end

        ST_ENTRY: begin
          if (key_digit) begin
            if (digit_count < FULL) begin
              entry_value <= shifted;
              digit_count <= digit_count + CW'(1);
            end else begin
              overflow <= 1'b1;
            end
          end else if (key_star) begin
            entry_value <= '0;
            digit_count <= '0;
            state       <= ST_IDLE;
          end else if (key_hash) begin
            wr_en   <= 1'b1;
            wr_data <= entry_value;
            state   <= ST_COMMIT;
          end else if (expire) begin
            entry_value <= '0;
            digit_count <= '0;
            timeout     <= 1'b1;
            state       <= ST_IDLE;
          end
        end

        ST_COMMIT: begin
          // A concurrent pointer load overrides the post-write increment.
          if (!addr_load) begin
            wr_addr <= wr_addr + ADDR_W'(1);
          end
          entry_value <= '0;
          digit_count <= '0;
          state       <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
